control_sequencer: RTL and testbench

Multi-cycle instruction sequencer that drives the processor datapath. It fetches 16-bit instruction words from program memory and decodes them into `constants_pkg::ALUOp` commands (`REG_READ`, `REG_WRITE`, `ADD`, `SUB`). It issues each command to the ALU/register-file block over a start/done handshake. It sits between instruction memory and the ALU; the ALU is the consumer of the opcodes this block produces.

---
 rtl/control_sequencer.sv | 168 ++++++++++++++++
 tb/tb_control_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multi-cycle fetch/decode/issue sequencer driving the ALU over start/done

package constants_pkg;
  typedef enum logic [1:0] {
    REG_READ  = 2'd0,
    REG_WRITE = 2'd1,
    ADD       = 2'd2,
    SUB       = 2'd3
  } ALUOp;
endpackage

module control_sequencer #(
  parameter int unsigned          PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] pc,
  output logic                mem_rd,
  input  logic [15:0]         mem_data,
  output constants_pkg::ALUOp alu_op,
  output logic                alu_start,
  input  logic                alu_done,
  output logic [3:0]          dst_reg,
  output logic [3:0]          src_a,
  output logic [3:0]          src_b,
  output logic [7:0]          imm,
  output logic                halted,
  output logic                illegal
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_RD   = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    WAIT_MEM = 3'd1,
    DECODE   = 3'd2,
    ISSUE    = 3'd3,
    WAIT_ALU = 3'd4,
    HALTED   = 3'd5
  } state_t;

  state_t              state_q;
  state_t              state_n;
  logic [15:0]         ir_q;
  logic [PC_WIDTH-1:0] pc_n;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] jmp_target;
  logic                set_illegal;

  logic [3:0]          opcode;
  logic                is_alu;
  logic                is_jmp;
  logic                is_halt;
  logic                is_nop;
  constants_pkg::ALUOp dec_op;

  // Operand fields come straight from the instruction register, so they stay
  // put from DECODE until the next instruction word is latched.
  assign opcode  = ir_q[15:12];
  assign dst_reg = ir_q[11:8];
  assign src_a   = ir_q[7:4];
  assign src_b   = ir_q[3:0];
  assign imm     = ir_q[7:0];

  assign pc_inc     = pc + PC_WIDTH'(1);
  assign jmp_target = PC_WIDTH'(ir_q[7:0]);

  // Classify the latched opcode and pick the ALU command it maps to.
  always_comb begin
    dec_op  = constants_pkg::REG_READ;
    is_alu  = 1'b0;
    is_jmp  = 1'b0;
    is_halt = 1'b0;
    is_nop  = 1'b0;
    case (opcode)
      OP_NOP:  is_nop = 1'b1;
      OP_LDI:  begin dec_op = constants_pkg::REG_WRITE; is_alu = 1'b1; end
      OP_ADD:  begin dec_op = constants_pkg::ADD;       is_alu = 1'b1; end
      OP_SUB:  begin dec_op = constants_pkg::SUB;       is_alu = 1'b1; end
      OP_RD:   begin dec_op = constants_pkg::REG_READ;  is_alu = 1'b1; end
      OP_JMP:  is_jmp  = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

  // Next-state and next-pc selection for the instruction cycle.
  always_comb begin
    state_n     = state_q;
    pc_n        = pc;
    set_illegal = 1'b0;
    case (state_q)
      // Reset lands here with the strobe low; one cycle is spent raising it
      // so every fetch cycle carries a visible mem_rd.
      FETCH: begin
        if (mem_rd) begin
          state_n = WAIT_MEM;
        end
      end
      WAIT_MEM: state_n = DECODE;
      DECODE: begin
        if (is_alu) begin
          state_n = ISSUE;
        end else if (is_jmp) begin
          pc_n    = jmp_target;
          state_n = FETCH;
        end else if (is_halt) begin
          state_n = HALTED;
        end else begin
          pc_n        = pc_inc;
          set_illegal = ~is_nop;
          state_n     = FETCH;
        end
      end
      ISSUE: state_n = WAIT_ALU;
      WAIT_ALU: begin
        if (alu_done) begin
          pc_n    = pc_inc;
          state_n = FETCH;
        end
      end
      HALTED:  state_n = HALTED;
      default: state_n = FETCH;
    endcase
  end

  // State register; reset aborts whatever instruction was in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_n;
    end
  end

  // Registered outputs, program counter and instruction register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      mem_rd    <= 1'b0;
      alu_start <= 1'b0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      alu_op    <= constants_pkg::REG_READ;
      ir_q      <= '0;
    end else begin
      pc        <= pc_n;
      mem_rd    <= (state_n == FETCH);
      alu_start <= (state_n == ISSUE);
      halted    <= (state_n == HALTED);
      illegal   <= illegal | set_illegal;
      if (state_q == WAIT_MEM) begin
        ir_q <= mem_data;
      end
      if (state_n == ISSUE) begin
        alu_op <= dec_op;
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer against an instruction-level model

module tb_control_sequencer;

  localparam logic [1:0] K_FETCH = 2'd0;
  localparam logic [1:0] K_START = 2'd1;
  localparam logic [1:0] K_HALT  = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  addr;
    logic        ill;
    logic [15:0] word;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [7:0]          pc;
  logic                mem_rd;
  logic [15:0]         mem_data = 16'h0;
  constants_pkg::ALUOp alu_op;
  logic                alu_start;
  logic                alu_done = 1'b0;
  logic [3:0]          dst_reg;
  logic [3:0]          src_a;
  logic [3:0]          src_b;
  logic [7:0]          imm;
  logic                halted;
  logic                illegal;

  control_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .pc(pc), .mem_rd(mem_rd), .mem_data(mem_data),
    .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done),
    .dst_reg(dst_reg), .src_a(src_a), .src_b(src_b), .imm(imm),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  logic [15:0] prog [0:255];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_rst_cyc = -10;
  int          last_done_cyc = -10;
  int          lat_fixed = 1;
  bit          stray_en = 1'b0;

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [1:0] op_of(input logic [3:0] opc);
    case (opc)
      4'h1:    return 2'(constants_pkg::REG_WRITE);
      4'h2:    return 2'(constants_pkg::ADD);
      4'h3:    return 2'(constants_pkg::SUB);
      default: return 2'(constants_pkg::REG_READ);
    endcase
  endfunction

  // Instruction-level model: walk the program and list the events the DUT must show.
  function automatic bit build_expect(input int max_instr);
    logic [7:0]  p;
    logic [15:0] w;
    bit          ill;
    exp_t        e;
    p   = 8'h00;
    ill = 1'b0;
    exp_q.delete();
    for (int n = 0; n < max_instr; n++) begin
      w      = prog[p];
      e.kind = K_FETCH;
      e.addr = p;
      e.ill  = ill;
      e.word = w;
      exp_q.push_back(e);
      case (w[15:12])
        4'h1, 4'h2, 4'h3, 4'h4: begin
          e.kind = K_START;
          exp_q.push_back(e);
          p = p + 8'd1;
        end
        4'h8: p = w[7:0];
        4'hF: begin
          e.kind = K_HALT;
          exp_q.push_back(e);
          return 1'b1;
        end
        4'h0: p = p + 8'd1;
        default: begin
          ill = 1'b1;
          p   = p + 8'd1;
        end
      endcase
    end
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) last_rst_cyc = cyc;
  end

  // Program memory: data for a strobe seen in cycle c is presented in cycle c+1, garbage otherwise.
  bit         rd_pend = 1'b0;
  logic [7:0] rd_addr = 8'h00;
  always @(negedge clk) begin
    mem_data = rd_pend ? prog[rd_addr] : 16'($urandom);
    rd_pend  = mem_rd;
    rd_addr  = pc;
  end

  // ALU responder: done after a latency, plus optional stray pulses while idle.
  bit busy = 1'b0;
  int cnt = 0;
  always @(negedge clk) begin
    alu_done = 1'b0;
    if (busy) begin
      if (cnt <= 1) begin
        alu_done      = 1'b1;
        busy          = 1'b0;
        last_done_cyc = cyc;
      end else begin
        cnt = cnt - 1;
      end
    end else if (alu_start) begin
      busy = 1'b1;
      cnt  = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4));
    end else if (stray_en && ($urandom_range(0, 3) == 0)) begin
      alu_done = 1'b1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT shows a strobe or enters halt.
  bit         first_fetch = 1'b1;
  bit         prev_alu = 1'b0;
  bit         halt_seen = 1'b0;
  int         prev_fetch = -10;
  logic [1:0] last_op = 2'd0;
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    int   want;
    if (cyc == last_rst_cyc) begin
      check("rst_pc", int'(pc), 0);
      check("rst_mem_rd", int'(mem_rd), 0);
      check("rst_alu_start", int'(alu_start), 0);
      check("rst_halted", int'(halted), 0);
      check("rst_illegal", int'(illegal), 0);
      check("rst_alu_op", int'(alu_op), int'(constants_pkg::REG_READ));
      check("rst_fields", int'({dst_reg, src_a, src_b, imm}), 0);
      first_fetch = 1'b1;
      prev_alu    = 1'b0;
      halt_seen   = 1'b0;
      last_op     = 2'(constants_pkg::REG_READ);
    end else begin
      if (mem_rd && alu_start) check("strobe_overlap", 1, 0);
      if (mem_rd) begin
        ok = (exp_q.size() != 0) && (exp_q[0].kind == K_FETCH);
        check("fetch_expected", int'(ok), 1);
        if (ok) begin
          e    = exp_q.pop_front();
          want = first_fetch ? last_rst_cyc + 1 : (prev_alu ? last_done_cyc + 1 : prev_fetch + 3);
          check("fetch_pc", int'(pc), int'(e.addr));
          check("fetch_cycle", cyc, want);
          check("illegal_flag", int'(illegal), int'(e.ill));
          check("alu_op_hold", int'(alu_op), int'(last_op));
        end
        prev_fetch  = cyc;
        first_fetch = 1'b0;
        prev_alu    = 1'b0;
      end
      if (alu_start) begin
        ok = (exp_q.size() != 0) && (exp_q[0].kind == K_START);
        check("start_expected", int'(ok), 1);
        if (ok) begin
          e = exp_q.pop_front();
          check("start_cycle", cyc, prev_fetch + 3);
          check("alu_op", int'(alu_op), int'(op_of(e.word[15:12])));
          check("dst_reg", int'(dst_reg), int'(e.word[11:8]));
          check("src_a", int'(src_a), int'(e.word[7:4]));
          check("src_b", int'(src_b), int'(e.word[3:0]));
          check("imm", int'(imm), int'(e.word[7:0]));
          last_op = op_of(e.word[15:12]);
        end
        prev_alu = 1'b1;
      end
      if (halted && !halt_seen) begin
        ok = (exp_q.size() != 0) && (exp_q[0].kind == K_HALT);
        check("halt_expected", int'(ok), 1);
        if (ok) begin
          e = exp_q.pop_front();
          check("halt_cycle", cyc, prev_fetch + 3);
        end
        halt_seen = 1'b1;
      end else if (halt_seen) begin
        check("halted_sticky", int'(halted), 1);
      end
    end
  end

  // Called at the negedge that raised reset: reload the scoreboard in the reset cycle, then release.
  task automatic start_prog(input int max_instr, output bit will_halt);
    @(negedge clk);
    will_halt = build_expect(max_instr);
    reset = 1'b0;
  endtask

  task automatic drain(input bit will_halt);
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_timeout", exp_q.size(), 0);
    if (will_halt) begin
      repeat (20) begin
        @(negedge clk);
        check("halt_no_mem_rd", int'(mem_rd), 0);
        check("halt_no_alu_start", int'(alu_start), 0);
        check("halt_flag", int'(halted), 1);
      end
    end
    reset = 1'b1;
  endtask

  task automatic fill(input logic [15:0] w);
    for (int a = 0; a < 256; a++) prog[a] = w;
  endtask

  initial begin
    bit         wh;
    bit         found;
    int         r;
    logic [3:0] opc;
    logic [3:0] ill_ops [9];
    ill_ops = '{4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};

    reset = 1'b1;
    repeat (2) @(negedge clk);

    fill(16'hF000);
    prog[0] = 16'h1A5C;
    lat_fixed = 1; stray_en = 1'b0;
    start_prog(10, wh); drain(wh);

    fill(16'hF000);
    prog[0] = 16'h2312; prog[1] = 16'h3456;
    lat_fixed = 3; stray_en = 1'b1;
    start_prog(10, wh); drain(wh);

    fill(16'h0000);
    prog[0] = 16'h80FE;
    lat_fixed = 1;
    start_prog(9, wh); drain(wh);

    fill(16'hF000);
    prog[0] = 16'h8080; prog[8'h80] = 16'h4070;
    start_prog(10, wh); drain(wh);

    fill(16'hF000);
    prog[0] = 16'h7000; prog[1] = 16'h1234;
    lat_fixed = 2;
    start_prog(10, wh); drain(wh);

    fill(16'hF000);
    prog[0] = 16'h5000; prog[1] = 16'h2312;
    lat_fixed = 5; stray_en = 1'b0;
    start_prog(10, wh);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (alu_start) begin
        found = 1'b1;
        break;
      end
    end
    check("midop_start_seen", int'(found), 1);
    @(negedge clk);
    reset = 1'b1;
    start_prog(10, wh); drain(wh);

    for (int t = 0; t < 6; t++) begin
      for (int a = 0; a < 256; a++) begin
        r = int'($urandom_range(0, 99));
        if (r < 12)      opc = 4'h0;
        else if (r < 28) opc = 4'h1;
        else if (r < 44) opc = 4'h2;
        else if (r < 60) opc = 4'h3;
        else if (r < 72) opc = 4'h4;
        else if (r < 80) opc = 4'h8;
        else if (r < 96) opc = ill_ops[$urandom_range(0, 8)];
        else             opc = 4'hF;
        prog[a] = {opc, 12'($urandom)};
      end
      lat_fixed = 0; stray_en = 1'b1;
      start_prog(40, wh); drain(wh);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
